// File: rtl/synchronous_fifo_2.sv
// synchronous_fifo_2: single-clock FIFO with wrap-bit pointers and full/empty flags
module synchronous_fifo_2 #(
  parameter int DATA_WIDTH = 8,
  parameter int DEPTH = 8
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  w_en,
  input  logic                  r_en,
  input  logic [DATA_WIDTH-1:0] data_in,
  output logic [DATA_WIDTH-1:0] data_out,
  output logic                  full,
  output logic                  empty
);
  localparam int AW = $clog2(DEPTH);
  logic [AW:0] wr_ptr, rd_ptr;
  logic [DATA_WIDTH-1:0] mem [DEPTH];
  logic w_ok, r_ok;
  assign empty = wr_ptr == rd_ptr;
  assign full = wr_ptr[AW-1:0] == rd_ptr[AW-1:0] && wr_ptr[AW] != rd_ptr[AW];
  assign w_ok = w_en && !full;
  assign r_ok = r_en && !empty;
  // storage array; contents are not reset and only matter once written
  always_ff @(posedge clk)
    if (w_ok) mem[wr_ptr[AW-1:0]] <= data_in;
  // pointers advance on accepted requests; data_out only changes on an accepted read
  always_ff @(posedge clk or negedge rst)
    if (!rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      data_out <= '0;
    end else begin
      if (w_ok) wr_ptr <= wr_ptr + 1'b1;
      if (r_ok) begin
        rd_ptr <= rd_ptr + 1'b1;
        data_out <= mem[rd_ptr[AW-1:0]];
      end
    end
endmodule

// File: tb/tb_synchronous_fifo_2.sv
// tb_synchronous_fifo_2: directed self-checking bench for synchronous_fifo_2
module tb_synchronous_fifo_2;
  logic clk = 0, rst = 0, w_en = 0, r_en = 0;
  logic [7:0] data_in = 0, data_out;
  logic full, empty;
  int n_cmp = 0, n_fail = 0;
  synchronous_fifo_2 #(.DATA_WIDTH(8), .DEPTH(8)) dut (
    .clk(clk), .rst(rst), .w_en(w_en), .r_en(r_en),
    .data_in(data_in), .data_out(data_out), .full(full), .empty(empty)
  );
  always #2 clk = ~clk;
  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end
  task automatic cyc(input logic w, input logic r, input logic [7:0] d);
    w_en = w;
    r_en = r;
    data_in = d;
    @(posedge clk);
    #1;
    w_en = 0;
    r_en = 0;
  endtask
  task automatic test_reset;
    #1;
    n_cmp++;
    if ({full, empty, data_out} !== {1'b0, 1'b1, 8'h00}) begin
      n_fail++;
      $display("FAIL reset_init: got full=%b empty=%b data_out=%h want 0 1 00", full, empty, data_out);
    end
    @(posedge clk);
    #1 rst = 1;
    for (int i = 0; i < 4; i++) cyc(1, 0, 8'hA1 + 8'(i));
    cyc(0, 1, 0);
    n_cmp++;
    if ({full, empty, data_out} !== {1'b0, 1'b0, 8'hA1}) begin
      n_fail++;
      $display("FAIL reset_prefill: got full=%b empty=%b data_out=%h want 0 0 a1", full, empty, data_out);
    end
    rst = 0;
    #1;
    n_cmp++;
    if ({full, empty, data_out} !== {1'b0, 1'b1, 8'h00}) begin
      n_fail++;
      $display("FAIL reset_async: got full=%b empty=%b data_out=%h want 0 1 00", full, empty, data_out);
    end
    cyc(1, 1, 8'hFF);
    n_cmp++;
    if ({full, empty, data_out} !== {1'b0, 1'b1, 8'h00}) begin
      n_fail++;
      $display("FAIL reset_hold: got full=%b empty=%b data_out=%h want 0 1 00", full, empty, data_out);
    end
    rst = 1;
    cyc(0, 1, 0);
    n_cmp++;
    if ({full, empty, data_out} !== {1'b0, 1'b1, 8'h00}) begin
      n_fail++;
      $display("FAIL reset_read_ignored: got full=%b empty=%b data_out=%h want 0 1 00", full, empty, data_out);
    end
  endtask
  task automatic test_fill;
    for (int i = 0; i < 10; i++) begin
      cyc(1, 0, 8'h11 + 8'(i));
      n_cmp++;
      if ({full, empty, data_out} !== {i >= 7, 1'b0, 8'h00}) begin
        n_fail++;
        $display("FAIL fill_%0d: got full=%b empty=%b data_out=%h want %b 0 00", i, full, empty, data_out, i >= 7);
      end
    end
  endtask
  task automatic test_drain;
    for (int i = 0; i < 10; i++) begin
      cyc(0, 1, 0);
      n_cmp++;
      if ({full, empty, data_out} !== {1'b0, i >= 7, 8'h11 + 8'(i < 7 ? i : 7)}) begin
        n_fail++;
        $display("FAIL drain_%0d: got full=%b empty=%b data_out=%h want 0 %b %h", i, full, empty, data_out, i >= 7, 8'h11 + 8'(i < 7 ? i : 7));
      end
    end
  endtask
  task automatic test_wrap;
    for (int k = 0; k < 3; k++) begin
      for (int j = 0; j < 5; j++) begin
        cyc(1, 0, 8'h20 + 8'(5 * k + j));
        n_cmp++;
        if ({full, empty} !== 2'b00) begin
          n_fail++;
          $display("FAIL wrap_wr_%0d_%0d: got full=%b empty=%b want 0 0", k, j, full, empty);
        end
      end
      for (int j = 0; j < 5; j++) begin
        cyc(0, 1, 0);
        n_cmp++;
        if ({full, empty, data_out} !== {1'b0, j == 4, 8'h20 + 8'(5 * k + j)}) begin
          n_fail++;
          $display("FAIL wrap_rd_%0d_%0d: got full=%b empty=%b data_out=%h want 0 %b %h", k, j, full, empty, data_out, j == 4, 8'h20 + 8'(5 * k + j));
        end
      end
    end
  endtask
  task automatic test_back_to_back;
    for (int i = 0; i < 3; i++) cyc(1, 0, 8'h30 + 8'(i));
    for (int i = 0; i < 10; i++) begin
      cyc(1, 1, 8'h33 + 8'(i));
      n_cmp++;
      if ({full, empty, data_out} !== {1'b0, 1'b0, 8'h30 + 8'(i)}) begin
        n_fail++;
        $display("FAIL simul_%0d: got full=%b empty=%b data_out=%h want 0 0 %h", i, full, empty, data_out, 8'h30 + 8'(i));
      end
    end
    for (int i = 0; i < 3; i++) begin
      cyc(0, 1, 0);
      n_cmp++;
      if ({full, empty, data_out} !== {1'b0, i == 2, 8'h3A + 8'(i)}) begin
        n_fail++;
        $display("FAIL simul_tail_%0d: got full=%b empty=%b data_out=%h want 0 %b %h", i, full, empty, data_out, i == 2, 8'h3A + 8'(i));
      end
    end
  endtask
  task automatic test_full_simul;
    for (int i = 0; i < 8; i++) cyc(1, 0, 8'h50 + 8'(i));
    n_cmp++;
    if (full !== 1'b1) begin
      n_fail++;
      $display("FAIL full_before_pulse: got full=%b want 1", full);
    end
    cyc(1, 1, 8'hEE);
    n_cmp++;
    if ({full, empty, data_out} !== {1'b0, 1'b0, 8'h50}) begin
      n_fail++;
      $display("FAIL full_pulse: got full=%b empty=%b data_out=%h want 0 0 50", full, empty, data_out);
    end
    for (int i = 0; i < 8; i++) begin
      cyc(0, 1, 0);
      n_cmp++;
      if ({full, empty, data_out} !== {1'b0, i >= 6, 8'h51 + 8'(i < 6 ? i : 6)}) begin
        n_fail++;
        $display("FAIL full_drain_%0d: got full=%b empty=%b data_out=%h want 0 %b %h", i, full, empty, data_out, i >= 6, 8'h51 + 8'(i < 6 ? i : 6));
      end
    end
  endtask
  task automatic test_stagger(input int lag, input logic [7:0] base);
    logic [7:0] q[$];
    logic [7:0] exp_out;
    exp_out = data_out;
    for (int t = 0; t < lag + 10; t++) begin
      logic w, r, wok, rok;
      w = t < 10;
      r = t >= lag;
      wok = w && q.size() < 8;
      rok = r && q.size() > 0;
      if (rok) exp_out = q.pop_front();
      if (wok) q.push_back(base + 8'(t));
      cyc(w, r, base + 8'(t));
      n_cmp++;
      if ({full, empty, data_out} !== {q.size() == 8, q.size() == 0, exp_out}) begin
        n_fail++;
        $display("FAIL stagger_%0d_t%0d: got full=%b empty=%b data_out=%h want %b %b %h", lag, t, full, empty, data_out, q.size() == 8, q.size() == 0, exp_out);
      end
    end
  endtask
  initial begin
    test_reset;
    test_fill;
    test_drain;
    test_wrap;
    test_back_to_back;
    test_full_simul;
    test_stagger(5, 8'h40);
    test_stagger(10, 8'h60);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end
endmodule

// File: doc/synchronous_fifo_2.md
# synchronous_fifo_2

Single-clock first-in/first-out buffer with a parameterized data width and depth. It decouples a producer and a consumer that share one clock. Writes and reads are qualified by enables. Full and empty flags tell each side when it must stall.

## Interface
Parameters:
- DATA_WIDTH, default 8: width of each stored word.
- DEPTH, default 8: number of storage entries; must be a power of two and at least 2.

Ports:
- clk  input  1  system clock; all state changes on the rising edge.
- rst  input  1  reset, asynchronous and active-low; clears pointers and output.
- w_en  input  1  write request.
- r_en  input  1  read request.
- data_in  input  DATA_WIDTH  word to write.
- data_out  output  DATA_WIDTH  registered read data.
- full  output  1  high when DEPTH words are stored.
- empty  output  1  high when no words are stored.

One clock; reset is asynchronous and active-low.

## Operation
- Storage is a DEPTH-entry register array, indexed by a write pointer and a read pointer.
- Each pointer is log2(DEPTH)+1 bits wide. The low bits are the array index. The MSB is a wrap bit that toggles on each pass through the array.
- empty = (wr_ptr == rd_ptr), all bits compared.
- full = (index bits equal) AND (wrap bits differ).
- Both flags are combinational decodes of the registered pointers, so they are glitch-free relative to clk.
- Accepted write: w_en && !full. Store data_in at mem[wr_ptr index], then increment wr_ptr.
- Accepted read: r_en && !empty. Load data_out from mem[rd_ptr index], then increment rd_ptr.
- Rejected write (w_en while full): ignored. No pointer change, no array change, no error output.
- Rejected read (r_en while empty): ignored. data_out holds its previous value.
- Simultaneous w_en and r_en:
  - Each is judged independently against the flags as they stand before the edge.
  - Neither full nor empty: both happen; occupancy is unchanged; the flags stay as they were.
  - Full: only the read happens; full deasserts after the edge.
  - Empty: only the write happens; empty deasserts after the edge. The written word is not bypassed to data_out.
- Pointer increments wrap modulo 2*DEPTH. The index wraps modulo DEPTH.
- Array contents are not cleared by reset. They are don't-care until written.

## Timing
- Reset (rst low, asynchronous, immediate): wr_ptr=0, rd_ptr=0, data_out=0, empty=1, full=0. The block stays in this state while rst is low. Deasserting rst takes effect at the next rising edge.
- Reset asserted mid-operation: all stored words are discarded; the outputs return to their reset values at once.
- Write latency: a word written at edge N is readable by an r_en sampled at edge N+1.
- Read latency: data_out shows the new word just after the edge that samples an accepted r_en. It stays stable until the next accepted read or reset.
- Flag update: full and empty reflect the pointers right after each edge, so a producer that samples full before the next edge never overflows the FIFO.
- Throughput: one write and one read per clock, sustained.

## Test plan
- Reset: assert rst low while the FIFO is half full. Required: empty=1, full=0 and data_out=0 immediately; after release, a read with r_en=1 is ignored.
- Fill and overflow (DEPTH=8): write 0x11…0x1A, one per clock, with no reads. Required: full rises after the 8th write; 0x19 and 0x1A are dropped; full stays 1.
- Drain and underflow: from the full state above, assert r_en for 10 cycles. Required: data_out is 0x11…0x18 in order; empty rises after the 8th read; the last two reads leave data_out=0x18.
- Wrap-around: run 3 cycles of "write 5 words, read 5 words" with incrementing data. Required: every word is read back in order across the index wrap; full never asserts; empty asserts at the end of each cycle.
- Simultaneous read and write:
  - With 3 words stored, hold w_en=r_en=1 for 10 clocks. Required: the count stays 3, data order is preserved, and neither flag asserts.
  - With the FIFO full, pulse w_en=r_en=1 once. Required: the oldest word is read, the new word is dropped, and full=0 after the edge.
- Staggered producer and consumer: start 10 writes, one per clock; start 10 reads 20 time units (5 clocks) later; repeat with a 40-unit (10-clock) lag. Required: no word is duplicated or lost other than those dropped while full; output order matches input order.
